// File: rtl/rv16_pkg.sv
// Shared definitions for the 16-bit RISC core.
// Opcode map, field positions and PC-redirect target helpers.
package rv16_pkg;

  localparam int INSTR_W  = 16;
  localparam int OPC_MSB  = 15;
  localparam int OFF6_MSB = 5;
  localparam int JOFF_MSB = 11;

  localparam logic [3:0] OPC_LW  = 4'h0;
  localparam logic [3:0] OPC_SW  = 4'h1;
  localparam logic [3:0] OPC_BEQ = 4'hB;
  localparam logic [3:0] OPC_BNE = 4'hC;
  localparam logic [3:0] OPC_J   = 4'hD;

  typedef logic [INSTR_W-1:0] word_t;

  function automatic word_t br_target(word_t pc, word_t instr);
    word_t off;
    off = {{9{instr[OFF6_MSB]}}, instr[OFF6_MSB:0], 1'b0};
    return pc + 16'd2 + off;
  endfunction

  // Jump stays inside the 8 KiB region of pc+2.
  function automatic word_t j_target(word_t pc, word_t instr);
    word_t pc2;
    pc2 = pc + 16'd2;
    return {pc2[15:13], instr[JOFF_MSB:0], 1'b0};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bundle.
// master = fetch unit, slave = memory.
interface instr_fetch_unit_if;
  import rv16_pkg::*;

  logic  imem_req_valid;
  logic  imem_req_ready;
  word_t imem_req_addr;
  logic  imem_rsp_valid;
  word_t imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/instr_fetch_unit_sync_fifo.sv
// Synchronous FIFO with wrap-around pointers and a count register.
// Push while full is accepted only when a pop frees a slot the same cycle.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop & (count_q != '0);
    do_push  = push & ((count_q != CW'(DEPTH)) | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: in-order imem requests, instruction FIFO,
// and redirect on taken branch/jump with in-flight response discard.
module instr_fetch_unit
  import rv16_pkg::*;
#(
  parameter word_t RESET_PC        = 16'h0000,
  parameter int    BUF_DEPTH       = 4,
  parameter int    MAX_OUTSTANDING = 2
) (
  input  logic  clk,
  input  logic  reset,
  instr_fetch_unit_if.master imem,
  output logic  instr_valid,
  input  logic  instr_ready,
  output word_t instr_out,
  output word_t pc_out,
  input  logic  ex_valid,
  input  logic  ex_jump,
  input  logic  ex_beq,
  input  logic  ex_bne,
  input  logic  ex_zero,
  input  word_t ex_pc,
  input  word_t ex_instr,
  output logic  redirect
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  word_t         fetch_pc_q, fetch_pc_d;
  word_t         head_pc_q, head_pc_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] discard_q, discard_d;
  logic [CW-1:0] fifo_count;
  word_t         fifo_rdata;
  word_t         target;
  logic          accept, rsp_dec, push, pop, room;

  sync_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (push),
    .wdata (imem.imem_rsp_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

  always_comb begin
    redirect = ~reset & ex_valid &
               (ex_jump | (ex_beq & ex_zero) | (ex_bne & ~ex_zero));
    target = ex_jump ? j_target(ex_pc, ex_instr)
                     : br_target(ex_pc, ex_instr);

    room = (int'(fifo_count) + int'(outstanding_q)) < BUF_DEPTH;
    imem.imem_req_valid = ~reset & ~redirect & room &
                          (int'(outstanding_q) < MAX_OUTSTANDING);
    imem.imem_req_addr  = reset ? RESET_PC : fetch_pc_q;
    accept = imem.imem_req_valid & imem.imem_req_ready;

    // Responses to pre-reset requests must not underflow the counter.
    rsp_dec = imem.imem_rsp_valid & (outstanding_q != '0);
    outstanding_d = outstanding_q + OW'(accept) - OW'(rsp_dec);

    instr_valid = ~reset & (fifo_count != '0);
    instr_out   = instr_valid ? fifo_rdata : '0;
    pc_out      = instr_valid ? head_pc_q : '0;

    push = imem.imem_rsp_valid & (discard_q == '0) & ~redirect;
    pop  = instr_valid & instr_ready & ~redirect;

    discard_d  = discard_q;
    fetch_pc_d = fetch_pc_q;
    head_pc_d  = head_pc_q;
    if (redirect) begin
      discard_d  = outstanding_d;
      fetch_pc_d = target;
      head_pc_d  = target;
    end else begin
      if (imem.imem_rsp_valid && discard_q != '0)
        discard_d = discard_q - 1'b1;
      if (accept) fetch_pc_d = fetch_pc_q + 16'd2;
      if (pop)    head_pc_d  = head_pc_q + 16'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      head_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      head_pc_q     <= head_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit with a queued imem model.
// Directed phases push expected (pc, word) pairs; a monitor checks pops.
module tb_instr_fetch_unit;
  import rv16_pkg::*;

  logic  clk = 1'b0;
  logic  reset;
  logic  instr_valid, instr_ready;
  word_t instr_out, pc_out;
  logic  ex_valid, ex_jump, ex_beq, ex_bne, ex_zero;
  word_t ex_pc, ex_instr;
  logic  redirect;

  instr_fetch_unit_if imem ();

  instr_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (imem),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .pc_out      (pc_out),
    .ex_valid    (ex_valid),
    .ex_jump     (ex_jump),
    .ex_beq      (ex_beq),
    .ex_bne      (ex_bne),
    .ex_zero     (ex_zero),
    .ex_pc       (ex_pc),
    .ex_instr    (ex_instr),
    .redirect    (redirect)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic word_t mem_word(word_t a);
    return (a * 16'd7) ^ 16'hB3C5;
  endfunction

  // Memory model: responds in order, 1+ cycles after acceptance.
  word_t pend_q[$];
  int    due_q[$];
  int    cyc = 0;
  bit    mem_stall = 0;
  bit    mem_one = 0;

  initial begin
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (imem.imem_req_valid && imem.imem_req_ready) begin
        pend_q.push_back(imem.imem_req_addr);
        due_q.push_back(cyc + 1);
      end
      @(posedge clk);
      cyc++;
      #2;
      if (pend_q.size() > 0 && due_q[0] <= cyc &&
          (!mem_stall || mem_one)) begin
        imem.imem_rsp_valid = 1'b1;
        imem.imem_rsp_data  = mem_word(pend_q.pop_front());
        void'(due_q.pop_front());
        mem_one = 0;
      end else begin
        imem.imem_rsp_valid = 1'b0;
      end
    end
  end

  typedef struct {
    word_t pc;
    word_t ins;
  } exp_t;
  exp_t exp_q[$];

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && instr_valid && instr_ready && !redirect) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pop: pc_out %h instr_out %h, none expected",
                   pc_out, instr_out);
        end else begin
          e = exp_q.pop_front();
          check("pop_pc", 32'(pc_out), 32'(e.pc));
          check("pop_instr", 32'(instr_out), 32'(e.ins));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_jump = 0; ex_beq = 0; ex_bne = 0; ex_zero = 0;
    ex_pc = '0; ex_instr = '0;
  endtask

  // Consume exactly n words; reports accept/valid cycle indices.
  task automatic take_n(input word_t start, input int n,
                        output int first_acc, output int first_v,
                        output int last_v);
    int k = 0;
    int w = 0;
    exp_t e;
    first_acc = -1;
    first_v = -1;
    last_v = -1;
    for (int i = 0; i < n; i++) begin
      e.pc  = start + word_t'(2 * i);
      e.ins = mem_word(e.pc);
      exp_q.push_back(e);
    end
    instr_ready = 1;
    while (k < n && w < 60) begin
      @(negedge clk);
      if (first_acc < 0 && imem.imem_req_valid && imem.imem_req_ready)
        first_acc = w;
      if (instr_valid && !redirect) begin
        if (first_v < 0) first_v = w;
        last_v = w;
        k++;
      end
      w++;
    end
    if (k < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL take_timeout: got %0d words expected %0d", k, n);
    end
    step();
    instr_ready = 0;
  endtask

  initial begin
    int fa, fv, lv;
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int fa, fv, lv;
    reset = 1;
    instr_ready = 0;
    imem.imem_req_ready = 1;
    clear_ex();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_instr_valid", 32'(instr_valid), 0);
    check("rst_req_valid", 32'(imem.imem_req_valid), 0);
    check("rst_req_addr", 32'(imem.imem_req_addr), 32'h0000);
    check("rst_redirect", 32'(redirect), 0);
    check("rst_pc_out", 32'(pc_out), 0);
    step();
    reset = 0;

    // Phase 1: streaming with zero-wait memory
    take_n(16'h0000, 8, fa, fv, lv);
    check("first_latency_ge2", 32'((fv - fa) >= 2), 1);
    check("stream_one_per_cycle", 32'(lv - fv), 7);

    // Phase 2: decode stall fills the buffer
    repeat (10) step();
    @(negedge clk);
    check("stall_req_valid", 32'(imem.imem_req_valid), 0);
    check("stall_fifo_count", 32'(dut.fifo_count), 4);
    check("stall_outstanding", 32'(dut.outstanding_q), 0);
    check("stall_head_pc", 32'(pc_out), 32'h0010);
    step();
    take_n(16'h0010, 6, fa, fv, lv);
    check("release_one_per_cycle", 32'(lv - fv), 5);
    repeat (8) step();
    @(negedge clk);
    check("refill_fifo_count", 32'(dut.fifo_count), 4);

    // Phase 6: reset mid-stall with full buffer
    step();
    reset = 1;
    mem_stall = 1;
    step();
    reset = 0;
    @(negedge clk);
    check("midrst_instr_valid", 32'(instr_valid), 0);
    check("midrst_req_addr", 32'(imem.imem_req_addr), 32'h0000);
    check("midrst_outstanding", 32'(dut.outstanding_q), 0);

    // Phase 3: BEQ taken with two requests in flight
    step();
    step();
    ex_valid = 1; ex_beq = 1; ex_zero = 1;
    ex_pc = 16'h0010; ex_instr = 16'hB03E;
    @(negedge clk);
    check("beq_redirect", 32'(redirect), 1);
    check("beq_req_valid", 32'(imem.imem_req_valid), 0);
    check("beq_outstanding", 32'(dut.outstanding_q), 2);
    step();
    clear_ex();
    @(negedge clk);
    check("beq_req_addr", 32'(imem.imem_req_addr), 32'h000E);
    check("beq_discard", 32'(dut.discard_q), 2);
    check("beq_flushed", 32'(instr_valid), 0);
    step();
    mem_stall = 0;
    take_n(16'h000E, 3, fa, fv, lv);

    // Phase 4: BNE not taken, then J with beq also set
    ex_valid = 1; ex_bne = 1; ex_zero = 1;
    ex_pc = 16'h0010; ex_instr = 16'hC03E;
    @(negedge clk);
    check("bne_no_redirect", 32'(redirect), 0);
    step();
    clear_ex();
    take_n(16'h0014, 2, fa, fv, lv);
    ex_valid = 1; ex_jump = 1; ex_beq = 1; ex_zero = 1;
    ex_pc = 16'h2000; ex_instr = 16'hD123;
    @(negedge clk);
    check("j_redirect", 32'(redirect), 1);
    step();
    clear_ex();
    @(negedge clk);
    check("j_req_addr", 32'(imem.imem_req_addr), 32'h2246);
    step();
    take_n(16'h2246, 3, fa, fv, lv);

    // Phase 5: redirect while a response lands the same cycle
    repeat (8) step();
    mem_stall = 1;
    ex_valid = 1; ex_jump = 1;
    ex_pc = 16'h4000; ex_instr = 16'hD010;
    @(negedge clk);
    check("j2_redirect", 32'(redirect), 1);
    step();
    clear_ex();
    step();
    step();
    mem_one = 1;
    ex_valid = 1; ex_bne = 1; ex_zero = 0;
    ex_pc = 16'h4100; ex_instr = 16'hC004;
    @(negedge clk);
    check("overlap_redirect", 32'(redirect), 1);
    check("overlap_rsp_valid", 32'(imem.imem_rsp_valid), 1);
    check("overlap_outstanding", 32'(dut.outstanding_q), 2);
    step();
    clear_ex();
    mem_stall = 0;
    @(negedge clk);
    check("overlap_discard", 32'(dut.discard_q), 1);
    check("overlap_outstanding_after", 32'(dut.outstanding_q), 1);
    step();
    take_n(16'h410A, 2, fa, fv, lv);

    repeat (3) step();
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the 16-bit RISC core. It produces the instruction words whose opcode field [15:12] drives the decode/control stage.
- It consumes that stage's jump/beq/bne decisions, together with the ALU zero flag, to redirect the PC.
- It issues in-order requests to instruction memory through a valid/ready handshake and buffers the returned words in a small FIFO.
- It presents them to decode through a valid/ready handshake, with the PC of each word.

Parameters:
- RESET_PC, 16'h0000, PC loaded on reset.
- BUF_DEPTH, 4, instruction FIFO entries (power of two, ≥2); also the cap on buffered plus in-flight words.
- MAX_OUTSTANDING, 2, maximum imem requests issued but not yet answered.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  request to fetch imem_req_addr.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  16  byte address, always even.
- imem_rsp_valid  in  1  response word valid; responses return in request order, at least 1 cycle after acceptance.
- imem_rsp_data  in  16  instruction word.
- instr_valid  out  1  FIFO head is valid.
- instr_ready  in  1  decode consumes the head.
- instr_out  out  16  head instruction.
- pc_out  out  16  PC of the head instruction.
- ex_valid  in  1  execute-stage instruction resolved this cycle.
- ex_jump, ex_beq, ex_bne  in  1 each  control flags of the execute-stage instruction.
- ex_zero  in  1  ALU zero flag.
- ex_pc  in  16  PC of the execute-stage instruction.
- ex_instr  in  16  execute-stage instruction word (offset fields).
- redirect  out  1  combinational; a taken branch or jump is being applied this cycle.

Behaviour:
- Reset:
  - fetch_pc = RESET_PC; head_pc = RESET_PC.
  - FIFO empty; outstanding = 0; discard = 0.
  - All outputs 0, except imem_req_addr = RESET_PC.
  - Applies mid-transaction too; responses to pre-reset requests are not discarded.
- Taken condition: ex_valid & (ex_jump | (ex_beq & ex_zero) | (ex_bne & ~ex_zero)).
- Branch target: ex_pc + 2 + (sign_extend(ex_instr[5:0]) << 1), 16-bit wrap.
- Jump target: {pc2[15:13], ex_instr[11:0], 1'b0}, where pc2 = ex_pc + 2. ex_jump has priority over beq/bne.
- Issue condition: imem_req_valid = ~redirect & (outstanding < MAX_OUTSTANDING) & (fifo_count + outstanding < BUF_DEPTH).
  - imem_req_addr = fetch_pc.
  - On handshake: fetch_pc += 2 (wraps 16'hFFFE→0); outstanding += 1.
- Response:
  - outstanding -= 1 on each imem_rsp_valid; increment and decrement in the same cycle cancel.
  - If discard > 0: word dropped, discard -= 1.
  - Otherwise: word pushed to the FIFO. It never overflows, guaranteed by the issue condition.
- Pop:
  - instr_valid = fifo_count != 0.
  - On instr_valid & instr_ready: pop; head_pc += 2.
  - Data is registered-from-FIFO; latency from request acceptance is ≥2 cycles.
- Redirect cycle (redirect = 1):
  - FIFO flushed.
  - Any pop that cycle is void (instr_valid still reflects pre-flush state, but decode must ignore it under redirect).
  - fetch_pc = head_pc = target.
  - discard = outstanding_next, counting in-flight requests minus any response arriving this cycle.
  - No request is issued.
- A second redirect while discard > 0 overwrites discard with the current outstanding_next.
- Simultaneous push and pop with a full FIFO is allowed.
- The FIFO uses wrap-around pointers of log2(BUF_DEPTH) bits plus a count register.

Decomposition:
- Shared package rv16_pkg: OPC_LW=0, OPC_SW=1, OPC_BEQ=4'hB, OPC_BNE=4'hC, OPC_J=4'hD; INSTR_W=16; field slice constants (OPC_MSB=15, OFF6_MSB=5, JOFF_MSB=11).
- One sub-module: sync_fifo, parameterised by width and depth, used for the instruction buffer.

Test Plan:
- Reset then zero-wait memory with instr_ready=1 → requests at 0,2,4,…; first instr_valid ≥2 cycles after the first accept, pc_out = 0, then one word per cycle.
- instr_ready=0 for 10 cycles → exactly BUF_DEPTH words buffered, imem_req_valid=0 once fifo_count + outstanding = 4; no words lost or duplicated on release.
- BEQ at ex_pc=0x0010, ex_instr[5:0]=6'h3E (−2), ex_zero=1 → redirect=1, next imem_req_addr=0x000E, FIFO flushed, both in-flight responses dropped.
- BNE with ex_zero=1 → no redirect. J at ex_pc=0x2000, ex_instr[11:0]=0x123 → target 0x2246.
- Redirect while 2 requests are outstanding and one response arrives the same cycle → discard=1; the next response is dropped, the following one is pushed with pc_out=target.
- Assert reset mid-stall with a full FIFO → next cycle instr_valid=0, imem_req_addr=RESET_PC, outstanding=0.
